// File: rtl/core_pkg.sv
// core_pkg
//   Shared definitions for the hps_io ioctl helpers in this core.
//   - Upload/download file index constants as seen on ioctl_index.
//   - upl_state_t: state encoding of the upload responder FSM.
package core_pkg;

    localparam logic [7:0] UPLOAD_ROM     = 8'd0;
    localparam logic [7:0] UPLOAD_HISCORE = 8'd4;
    localparam logic [7:0] UPLOAD_NVRAM   = 8'd5;
    localparam logic [7:0] UPLOAD_DIP     = 8'd254;

    typedef enum logic [2:0] {
        UPL_IDLE     = 3'd0,
        UPL_PAUSE    = 3'd1,
        UPL_READY    = 3'd2,
        UPL_FETCH_LO = 3'd3,
        UPL_FETCH_HI = 3'd4,
        UPL_RESP     = 3'd5
    } upl_state_t;

endpackage

// File: rtl/ioctl_upload_responder.sv
// ioctl_upload_responder
//   Answers HPS-initiated uploads (core -> HPS) on the hps_io ioctl channel,
//   e.g. hiscore/NVRAM save. Every ioctl_rd is turned into two byte reads
//   from a byte-wide core RAM and answered with one 16-bit word. The core CPU
//   is asked to pause for as long as the upload is active.
//
// Ports
//   clk_sys       system clock
//   reset_n       synchronous active-low reset
//   ioctl_upload  upload active level from hps_io
//   ioctl_index   file index of the running upload
//   ioctl_rd      one-cycle read strobe for ioctl_addr
//   ioctl_addr    even byte address inside the upload
//   ioctl_din     read word, [7:0] = byte at addr, [15:8] = byte at addr+1
//   ioctl_wait    stall towards hps_io
//   pause_req     request to halt the core CPU
//   pause_ack     core CPU halted
//   mem_addr      RAM byte address
//   mem_req       RAM read request, held until mem_ack
//   mem_ack       one-cycle RAM ack, mem_dout valid in the same cycle
//   mem_dout      RAM read data
module ioctl_upload_responder
    import core_pkg::*;
#(
    parameter logic [7:0]        UPLOAD_INDEX = UPLOAD_HISCORE,
    parameter int                MEM_AW       = 12,
    parameter logic [MEM_AW-1:0] BASE         = 12'h000,
    parameter logic [MEM_AW:0]   LENGTH       = 13'd2048,
    parameter logic [15:0]       FILL         = 16'hFFFF
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              ioctl_upload,
    input  logic [7:0]        ioctl_index,
    input  logic              ioctl_rd,
    input  logic [26:0]       ioctl_addr,
    output logic [15:0]       ioctl_din,
    output logic              ioctl_wait,
    output logic              pause_req,
    input  logic              pause_ack,
    output logic [MEM_AW-1:0] mem_addr,
    output logic              mem_req,
    input  logic              mem_ack,
    input  logic [7:0]        mem_dout
);

    localparam logic [MEM_AW-1:0] ADDR_ONE = {{(MEM_AW-1){1'b0}}, 1'b1};

    upl_state_t  state_r;
    logic [7:0]  lo_r;          // low byte gathered in FETCH_LO
    logic        pend_r;        // read strobe seen while waiting for the pause
    logic [26:0] pend_addr_r;

    logic        active_s;
    logic        take_rd_s;
    logic [26:0] sel_addr_s;
    logic        in_range_s;

    // Upload qualification, read source selection and range check.
    always_comb begin
        active_s   = 1'b0;
        take_rd_s  = 1'b0;
        sel_addr_s = 27'd0;
        in_range_s = 1'b0;

        active_s  = ioctl_upload && (ioctl_index == UPLOAD_INDEX);
        take_rd_s = pend_r || ioctl_rd;
        if (pend_r) begin
            sel_addr_s = pend_addr_r;
        end else begin
            sel_addr_s = ioctl_addr;
        end
        // Zero-extended so addresses near 2^27 cannot wrap into range.
        in_range_s = ({1'b0, sel_addr_s} + 28'd1) < 28'(LENGTH);
    end

    // Upload FSM with registered outputs and byte-gather register.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state_r     <= UPL_IDLE;
            lo_r        <= 8'd0;
            pend_r      <= 1'b0;
            pend_addr_r <= 27'd0;
            ioctl_din   <= 16'd0;
            ioctl_wait  <= 1'b0;
            pause_req   <= 1'b0;
            mem_req     <= 1'b0;
            mem_addr    <= {MEM_AW{1'b0}};
        end else if (!active_s) begin
            // Upload ended or belongs to another index: drop everything,
            // discard any ack arriving now, keep the last word on ioctl_din.
            state_r    <= UPL_IDLE;
            pend_r     <= 1'b0;
            ioctl_wait <= 1'b0;
            pause_req  <= 1'b0;
            mem_req    <= 1'b0;
            mem_addr   <= {MEM_AW{1'b0}};
        end else begin
            case (state_r)
                UPL_IDLE: begin
                    state_r    <= UPL_PAUSE;
                    pend_r     <= 1'b0;
                    pause_req  <= 1'b1;
                    ioctl_wait <= 1'b1;
                end
                UPL_PAUSE: begin
                    if (ioctl_rd) begin
                        pend_r      <= 1'b1;
                        pend_addr_r <= ioctl_addr;
                    end
                    if (pause_ack) begin
                        state_r    <= UPL_READY;
                        // A read already accepted keeps hps_io stalled until
                        // its word is delivered.
                        ioctl_wait <= pend_r || ioctl_rd;
                    end
                end
                UPL_READY: begin
                    if (take_rd_s) begin
                        pend_r     <= 1'b0;
                        ioctl_wait <= 1'b1;
                        if (in_range_s) begin
                            state_r  <= UPL_FETCH_LO;
                            mem_addr <= BASE + sel_addr_s[MEM_AW-1:0];
                            mem_req  <= 1'b1;
                        end else begin
                            state_r   <= UPL_RESP;
                            ioctl_din <= FILL;
                        end
                    end
                end
                UPL_FETCH_LO: begin
                    if (mem_ack) begin
                        lo_r     <= mem_dout;
                        mem_addr <= mem_addr + ADDR_ONE;
                        state_r  <= UPL_FETCH_HI;
                    end
                end
                UPL_FETCH_HI: begin
                    if (mem_ack) begin
                        ioctl_din  <= {mem_dout, lo_r};
                        mem_req    <= 1'b0;
                        ioctl_wait <= 1'b0;
                        state_r    <= UPL_READY;
                    end
                end
                UPL_RESP: begin
                    ioctl_wait <= 1'b0;
                    state_r    <= UPL_READY;
                end
                default: begin
                    state_r    <= UPL_IDLE;
                    ioctl_wait <= 1'b0;
                    pause_req  <= 1'b0;
                    mem_req    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ioctl_upload_responder.sv
// tb_ioctl_upload_responder
//   Bench for ioctl_upload_responder: a RAM model with programmable ack
//   delay, a transaction-level model of the expected word and stall length,
//   and a per-cycle monitor of the idle/hold behaviour.
module tb_ioctl_upload_responder;
    import core_pkg::*;

    localparam int          LEN      = 2048;
    localparam logic [11:0] BASE_A   = 12'h000;
    localparam logic [15:0] FILL_W   = 16'hFFFF;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        ioctl_upload;
    logic [7:0]  ioctl_index;
    logic        ioctl_rd;
    logic [26:0] ioctl_addr;
    logic [15:0] ioctl_din;
    logic        ioctl_wait;
    logic        pause_req;
    logic        pause_ack;
    logic [11:0] mem_addr;
    logic        mem_req;
    logic        mem_ack;
    logic [7:0]  mem_dout;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [7:0]  ram [0:4095];
    int          ack_delay = 0;
    logic [11:0] exp_addr_q [$];
    logic [15:0] exp_din = 16'd0;
    bit          mon_en = 1'b0;
    bit          prev_quiet = 1'b1;
    int          rcnt = -1;

    always #5 clk_sys = ~clk_sys;

    ioctl_upload_responder dut (
        .clk_sys      (clk_sys),
        .reset_n      (reset_n),
        .ioctl_upload (ioctl_upload),
        .ioctl_index  (ioctl_index),
        .ioctl_rd     (ioctl_rd),
        .ioctl_addr   (ioctl_addr),
        .ioctl_din    (ioctl_din),
        .ioctl_wait   (ioctl_wait),
        .pause_req    (pause_req),
        .pause_ack    (pause_ack),
        .mem_addr     (mem_addr),
        .mem_req      (mem_req),
        .mem_ack      (mem_ack),
        .mem_dout     (mem_dout)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // RAM model: acks after ack_delay idle request cycles, checks addresses.
    always @(posedge clk_sys) begin
        #1;
        if (mem_req !== 1'b1) begin
            mem_ack = 1'b0;
            rcnt    = -1;
        end else begin
            if (rcnt < 0) rcnt = ack_delay;
            if (rcnt == 0) begin
                mem_ack  = 1'b1;
                mem_dout = ram[mem_addr];
                rcnt     = -1;
                if (exp_addr_q.size() == 0) begin
                    chk("mem_access_expected", 32'(exp_addr_q.size()), 32'd1);
                end else begin
                    chk("mem_addr", 32'(mem_addr), 32'(exp_addr_q.pop_front()));
                end
            end else begin
                mem_ack = 1'b0;
                rcnt--;
            end
        end
    end

    // Per-cycle monitor: quiet outputs after an inactive cycle, held read word.
    always @(negedge clk_sys) begin
        if (mon_en) begin
            if (prev_quiet) begin
                chk("quiet_pause_req", 32'(pause_req), 32'd0);
                chk("quiet_mem_req", 32'(mem_req), 32'd0);
                chk("quiet_wait", 32'(ioctl_wait), 32'd0);
            end
            if (ioctl_wait === 1'b0) chk("din_hold", 32'(ioctl_din), 32'(exp_din));
        end
        prev_quiet = !reset_n || !ioctl_upload || (ioctl_index != UPLOAD_HISCORE);
    end

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    // One read transaction: expected word and stall length from the rules.
    task automatic do_read(input logic [26:0] off, input int dly);
        bit          inr;
        logic [11:0] a0;
        logic [15:0] w;
        int          nw;
        bit          req_ok;
        inr = (longint'(off) + 64'sd1) < longint'(LEN);
        a0  = 12'(off) + BASE_A;
        if (inr) begin
            w = {ram[a0 + 12'd1], ram[a0]};
            exp_addr_q.push_back(a0);
            exp_addr_q.push_back(a0 + 12'd1);
        end else begin
            w = FILL_W;
        end
        ack_delay  = dly;
        ioctl_rd   = 1'b1;
        ioctl_addr = off;
        step();
        ioctl_rd = 1'b0;
        nw     = 0;
        req_ok = 1'b1;
        while (ioctl_wait === 1'b1 && nw < 100) begin
            if (mem_req !== inr) req_ok = 1'b0;
            nw++;
            step();
        end
        exp_din = w;
        chk("read_wait_cycles", 32'(nw), inr ? 32'(2 + 2 * dly) : 32'd1);
        chk("read_mem_req_shape", 32'(req_ok), 32'd1);
        chk("read_din", 32'(ioctl_din), 32'(w));
        chk("read_pause_req_held", 32'(pause_req), 32'd1);
        chk("read_all_bytes_fetched", 32'(exp_addr_q.size()), 32'd0);
        exp_addr_q.delete();
    endtask

    task automatic start_upload();
        ioctl_upload = 1'b1;
        ioctl_index  = UPLOAD_HISCORE;
        pause_ack    = 1'b0;
        step();
        chk("start_pause_req", 32'(pause_req), 32'd1);
        chk("start_wait", 32'(ioctl_wait), 32'd1);
        step();
        step();
        pause_ack = 1'b1;
        step();
        chk("start_release_wait", 32'(ioctl_wait), 32'd0);
    endtask

    initial begin
        int  i;
        int  n;
        bit  done;
        bit  early_req;
        logic [26:0] off;

        reset_n      = 1'b0;
        ioctl_upload = 1'b0;
        ioctl_index  = 8'd0;
        ioctl_rd     = 1'b0;
        ioctl_addr   = 27'd0;
        pause_ack    = 1'b0;
        mem_ack      = 1'b0;
        mem_dout     = 8'd0;
        for (int k = 0; k < 4096; k++) ram[k] = 8'($urandom);
        ram[0] = 8'h12;
        ram[1] = 8'h34;
        ram[2] = 8'hA5;
        ram[3] = 8'h5A;

        repeat (3) step();
        chk("rst_din", 32'(ioctl_din), 32'd0);
        chk("rst_wait", 32'(ioctl_wait), 32'd0);
        chk("rst_pause_req", 32'(pause_req), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        exp_din = 16'd0;
        mon_en  = 1'b1;

        // Upload starts, read at addr 0 lands during the pause handshake.
        reset_n      = 1'b1;
        ioctl_upload = 1'b1;
        ioctl_index  = UPLOAD_HISCORE;
        ack_delay    = 0;
        i = 0; n = 0; done = 1'b0; early_req = 1'b0;
        while (!done && i < 40) begin
            i++;
            step();
            if (i == 2) begin
                ioctl_rd   = 1'b1;
                ioctl_addr = 27'd0;
                exp_addr_q.push_back(12'h000);
                exp_addr_q.push_back(12'h001);
            end
            if (i == 3) ioctl_rd = 1'b0;
            if (i == 6) pause_ack = 1'b1;
            if (i <= 7 && mem_req === 1'b1) early_req = 1'b1;
            if (ioctl_wait === 1'b1) n++;
            else done = 1'b1;
        end
        exp_din = 16'h3412;
        chk("pause_rd_wait_cycles", 32'(n), 32'd9);
        chk("pause_rd_no_early_req", 32'(early_req), 32'd0);
        chk("pause_rd_din", 32'(ioctl_din), 32'h3412);
        chk("pause_rd_pause_req", 32'(pause_req), 32'd1);
        exp_addr_q.delete();

        // Directed reads: zero-wait, LENGTH boundary, last word, slow RAM.
        repeat (2) step();
        do_read(27'd2, 0);
        chk("addr2_din_literal", 32'(ioctl_din), 32'h5AA5);
        do_read(27'd2048, 0);
        chk("len_din_literal", 32'(ioctl_din), 32'hFFFF);
        do_read(27'd2046, 1);
        do_read(27'h7FF_FFFE, 0);
        do_read(27'd10, 3);
        repeat (4) step();

        // Randomized reads, gaps, RAM delays and pause_ack wobble.
        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 9) < 7) begin
                off = 27'(2 * $urandom_range(0, 1023));
            end else begin
                case ($urandom_range(0, 2))
                    0:       off = 27'd2048;
                    1:       off = 27'd2050;
                    default: off = 27'($urandom) & ~27'd1;
                endcase
            end
            pause_ack = 1'($urandom_range(0, 1));
            do_read(off, int'($urandom_range(0, 3)));
            repeat ($urandom_range(0, 3)) step();
        end

        // Upload dropped in FETCH_HI in the very cycle the high byte is acked.
        ack_delay  = 3;
        exp_addr_q.push_back(12'd20);
        exp_addr_q.push_back(12'd21);
        ioctl_rd   = 1'b1;
        ioctl_addr = 27'd20;
        step();
        ioctl_rd = 1'b0;
        repeat (7) step();
        ioctl_upload = 1'b0;
        step();
        chk("drop_pause_req", 32'(pause_req), 32'd0);
        chk("drop_mem_req", 32'(mem_req), 32'd0);
        chk("drop_wait", 32'(ioctl_wait), 32'd0);
        chk("drop_din_kept", 32'(ioctl_din), 32'(exp_din));
        exp_addr_q.delete();
        repeat (2) step();

        // Reset asserted while the low byte is outstanding.
        start_upload();
        do_read(27'd6, 0);
        ack_delay  = 3;
        exp_addr_q.push_back(12'd40);
        exp_addr_q.push_back(12'd41);
        ioctl_rd   = 1'b1;
        ioctl_addr = 27'd40;
        step();
        ioctl_rd = 1'b0;
        step();
        reset_n = 1'b0;
        step();
        exp_din = 16'd0;
        chk("midrst_din", 32'(ioctl_din), 32'd0);
        chk("midrst_wait", 32'(ioctl_wait), 32'd0);
        chk("midrst_pause_req", 32'(pause_req), 32'd0);
        chk("midrst_mem_req", 32'(mem_req), 32'd0);
        chk("midrst_mem_addr", 32'(mem_addr), 32'd0);
        exp_addr_q.delete();

        // Upload of another index must leave the block idle.
        reset_n      = 1'b1;
        ioctl_upload = 1'b1;
        ioctl_index  = 8'd0;
        pause_ack    = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            chk("other_index_pause_req", 32'(pause_req), 32'd0);
            if (k == 2) begin
                ioctl_rd   = 1'b1;
                ioctl_addr = 27'd4;
            end else begin
                ioctl_rd = 1'b0;
            end
        end
        chk("other_index_mem_req", 32'(mem_req), 32'd0);
        ioctl_upload = 1'b0;
        repeat (2) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
